// File: rtl/ladybird_irq_controller_pkg.sv
// Shared sizing, register map and FSM encoding for the interrupt controller.
package ladybird_irq_controller_pkg;

  localparam int unsigned N_IRQ_SRC  = 8;
  localparam int unsigned IRQ_ID_W   = $clog2(N_IRQ_SRC);
  localparam int unsigned CFG_ADDR_W = 2;

  typedef enum logic [CFG_ADDR_W-1:0] {
    IRQ_ENABLE = 2'd0,
    IRQ_EDGE   = 2'd1,
    IRQ_CLEAR  = 2'd2,
    IRQ_STATUS = 2'd3
  } irq_reg_e;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_CLAIMED = 2'd1,
    IRQ_GAP     = 2'd2
  } irq_state_e;

endpackage

// File: rtl/ladybird_irq_controller_priority_encoder.sv
// Finds the first set request bit, searching upward from start and wrapping.
module ladybird_irq_priority_encoder
  import ladybird_irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC = N_IRQ_SRC,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             found,
  output logic [ID_W-1:0]  idx
);

  int unsigned pos;

  // Walk from the farthest candidate back to start so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = 0;
    for (int k = int'(N_SRC) - 1; k >= 0; k--) begin
      pos = (32'(start) + 32'(k)) % N_SRC;
      if (req[ID_W'(pos)]) begin
        found = 1'b1;
        idx   = ID_W'(pos);
      end
    end
  end

endmodule

// File: rtl/ladybird_irq_controller.sv
// Interrupt controller: per-source latching/masking plus a claim/complete FSM.
// Optional: LADYBIRD_IRQ_ROUND_ROBIN_EN rotates the selection start past the last claim.
module ladybird_irq_controller
  import ladybird_irq_controller_pkg::*;
#(
  parameter int unsigned N_SRC = N_IRQ_SRC,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      src_i,
  input  logic                  cfg_we,
  input  logic [CFG_ADDR_W-1:0] cfg_addr,
  input  logic [N_SRC-1:0]      cfg_wdata,
  output logic [N_SRC-1:0]      cfg_rdata,
  output logic                  irq_o,
  output logic                  claim_valid,
  output logic [ID_W-1:0]       claim_id,
  input  logic                  complete_i
);

  irq_state_e       state_q, state_d;
  logic [N_SRC-1:0] enable_q, edge_q, pending_q, pending_d, src_q;
  logic [N_SRC-1:0] eligible, edge_set, clear_wr, clear_done;
  logic             sel_found;
  logic [ID_W-1:0]  sel_idx, start_idx, claim_id_d;
  logic             irq_d, claim_valid_d, take_claim;
  irq_reg_e         cfg_reg;

  assign cfg_reg  = irq_reg_e'(cfg_addr);
  assign eligible = pending_q & enable_q;

  // Configuration registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_q <= '0;
      edge_q   <= '0;
    end else if (cfg_we) begin
      case (cfg_reg)
        IRQ_ENABLE: enable_q <= cfg_wdata;
        IRQ_EDGE:   edge_q   <= cfg_wdata;
        default:    ;
      endcase
    end
  end

  always_comb begin
    case (cfg_reg)
      IRQ_ENABLE: cfg_rdata = enable_q;
      IRQ_EDGE:   cfg_rdata = edge_q;
      IRQ_CLEAR:  cfg_rdata = '0;
      IRQ_STATUS: cfg_rdata = eligible;
      default:    cfg_rdata = '0;
    endcase
  end

  // Edge sources latch until cleared; a new edge beats a same-cycle clear.
  assign edge_set   = src_i & ~src_q;
  assign clear_wr   = (cfg_we && cfg_reg == IRQ_CLEAR) ? cfg_wdata : '0;
  assign clear_done = (state_q == IRQ_CLAIMED && complete_i) ? (N_SRC'(1) << claim_id) : '0;
  assign pending_d  = (edge_q & ((pending_q & ~(clear_wr | clear_done)) | edge_set))
                    | (~edge_q & src_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q     <= '0;
      pending_q <= '0;
    end else begin
      src_q     <= src_i;
      pending_q <= pending_d;
    end
  end

`ifdef LADYBIRD_IRQ_ROUND_ROBIN_EN
  logic [ID_W-1:0] rr_ptr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (take_claim) begin
      rr_ptr_q <= ID_W'((32'(sel_idx) + 32'd1) % N_SRC);
    end
  end

  assign start_idx = rr_ptr_q;
`else
  assign start_idx = '0;
`endif

  ladybird_irq_priority_encoder #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio (
    .req   (eligible),
    .start (start_idx),
    .found (sel_found),
    .idx   (sel_idx)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IRQ_IDLE;
      irq_o       <= 1'b0;
      claim_valid <= 1'b0;
      claim_id    <= '0;
    end else begin
      state_q     <= state_d;
      irq_o       <= irq_d;
      claim_valid <= claim_valid_d;
      claim_id    <= claim_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IRQ_IDLE:    if (sel_found) state_d = IRQ_CLAIMED;
      IRQ_CLAIMED: if (complete_i) state_d = IRQ_GAP;
      IRQ_GAP:     state_d = IRQ_IDLE;
      default:     state_d = IRQ_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they flip with the state flop.
  always_comb begin
    take_claim    = (state_q == IRQ_IDLE) && (state_d == IRQ_CLAIMED);
    irq_d         = (state_d == IRQ_CLAIMED);
    claim_valid_d = (state_d == IRQ_CLAIMED);
    claim_id_d    = claim_id;
    if (take_claim) claim_id_d = sel_idx;
  end

endmodule

// File: doc/ladybird_irq_controller.md
Name: ladybird_irq_controller

Overview:
- Interrupt controller between GPIO (and future peripheral) interrupt sources and the core's single `pending`/`complete` pair.
- Replaces the OR-reduce / complete-broadcast scheme with the following:
  - per-source latching, masking and edge/level selection;
  - a claim/complete state machine, so exactly one source is in service at a time and the handler can read which one.
- Configured by the core through a small register port, mapped behind a crossbar peripheral slot.

Parameters:
- N_SRC, 8, number of interrupt sources (2..32).
- ID_W, $clog2(N_SRC), width of the claim id.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous assert, active-high; clears all state
- src_i  in  N_SRC  raw interrupt sources, already synchronous to clk
- cfg_we  in  1  register write strobe
- cfg_addr  in  2  register select: 0 ENABLE, 1 EDGE, 2 CLEAR, 3 STATUS
- cfg_wdata  in  N_SRC  write data
- cfg_rdata  out  N_SRC  read data for cfg_addr, combinational
- irq_o  out  1  interrupt request to core `pending`
- claim_valid  out  1  claim_id is meaningful
- claim_id  out  ID_W  index of the source in service
- complete_i  in  1  one-cycle pulse from core: handler finished

Behaviour:
- Reset values:
  - ENABLE=0, EDGE=0 (all level mode), pending=0, src_q=0.
  - irq_o=0, claim_valid=0, claim_id=0, FSM=IDLE.
  - Takes effect immediately on rst, including mid-service.
- Pending register, per bit i, updated each clk:
  - EDGE[i]=1: set on src_i[i] & ~src_q[i]. Clear on completion of claim i or on CLEAR write with bit i=1. Set wins over simultaneous clear.
  - EDGE[i]=0: pending[i] <= src_i[i]. CLEAR and completion have no effect.
- Register writes (cfg_we) take effect next cycle:
  - ENABLE/EDGE: full overwrite.
  - CLEAR: write-1-to-clear, reads 0.
  - STATUS: read-only, returns pending & ENABLE; writes ignored.
- Eligible vector: pending & ENABLE. Select lowest-index eligible bit.
- FSM states:
  - IDLE: if eligible != 0, latch claim_id and go to CLAIMED.
  - CLAIMED:
    - irq_o=1 and claim_valid=1, registered outputs.
    - Hold until complete_i=1.
    - On complete_i: issue clear for claim_id (edge mode) and go to GAP.
    - claim_id is stable throughout.
    - Disabling or clearing the claimed source does not retract irq_o.
  - GAP: one cycle with irq_o=0 and claim_valid=0, so the core sees a deassertion edge; then go to IDLE.
- complete_i outside CLAIMED: ignored.
- Latency:
  - Edge on src_i at cycle t: pending at t+1, CLAIMED (irq_o=1) at t+2.
  - Back-to-back service: complete at t, next irq_o at t+3 at the earliest.
- Level source still high after completion: re-claimed after GAP (level-triggered semantics).

Optional Feature:
- LADYBIRD_IRQ_ROUND_ROBIN_EN defined:
  - Selection starts at (last claimed id + 1) mod N_SRC and wraps; the pointer resets to 0.
  - The pointer updates when CLAIMED is entered.
  - Prevents a stuck low-index source from starving others.
- Undefined: fixed priority, lowest index wins.

Decomposition:
- ladybird_config gains:
  - N_IRQ_SRC=8;
  - IRQ_ID_W;
  - typedef enum irq_reg_e {IRQ_ENABLE, IRQ_EDGE, IRQ_CLEAR, IRQ_STATUS};
  - typedef enum irq_state_e {IRQ_IDLE, IRQ_CLAIMED, IRQ_GAP}.
- One combinational sub-module, ladybird_irq_priority_encoder: inputs are the request vector and start index; outputs are found flag and index. Handles the rotating search when round-robin is enabled, otherwise start index is tied to 0.

Test Plan:
- Reset, then ENABLE=0xFF, EDGE=0x00; drive src_i=0x04 -> irq_o=1, claim_id=2 at t+2; complete pulse -> GAP, then re-claim id 2 while src_i stays high.
- EDGE=0xFF, rising pulse on src_i[5] and src_i[1] in the same cycle -> claim 1 first; complete -> one cycle irq_o=0; then claim 5; after complete, STATUS reads 0x00.
- ENABLE=0x00, pulse edge source 3 -> no irq_o; STATUS=0x00 while pending[3]=1; write ENABLE=0x08 -> irq_o two cycles later, claim_id=3.
- During CLAIMED on id 4: write ENABLE=0x00 and CLEAR=0x10 -> irq_o stays 1 until complete_i. A CLEAR write coinciding with a new edge on bit 6 -> pending[6] remains set.
- Assert rst while CLAIMED -> irq_o and claim_valid drop without a clock edge; all registers read 0; complete_i pulse after reset is ignored.
- With LADYBIRD_IRQ_ROUND_ROBIN_EN and level sources 0 and 1 held high -> claims alternate 0,1,0,1; without the macro -> claims are 0,0,0.
